// File: rtl/rf_pkg.sv
// Shared types and address-class helpers for the windowed register file.
// Window arithmetic lives here so the address map and spill/fill walk agree.
package rf_pkg;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} rf_state_t;

  localparam int IN_BASE = 0;

  // Ceiling log2; used for every derived width in the register file.
  function automatic int rf_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int local_base(input int n);
    return n;
  endfunction

  function automatic int out_base(input int n);
    return 2 * n;
  endfunction

  function automatic int global_base(input int n);
    return 3 * n;
  endfunction

  // Physical index of word k of window win; windows step by 2n so OUT of one is IN of the next.
  function automatic int win_phys(input int n, input int m, input int f, input int win, input int k);
    return m + ((2 * n * win + k) % (2 * n * f));
  endfunction

endpackage

// File: rtl/rf_addr_map.sv
// Combinational logical-to-physical register translation for one port.
// Addresses past the last global report valid=0.
module rf_addr_map
  import rf_pkg::*;
#(
  parameter int N      = 3,
  parameter int F      = 4,
  parameter int M      = 5,
  parameter int ADDR_W = 4,
  parameter int WIN_W  = 2,
  parameter int PHYS_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIN_W-1:0]  cwin,
  output logic [PHYS_W-1:0] phys,
  output logic              valid
);

  always_comb begin
    phys  = '0;
    valid = 1'b0;
    if (int'(addr) < global_base(N)) begin
      phys  = PHYS_W'(win_phys(N, M, F, int'(cwin), int'(addr)));
      valid = 1'b1;
    end else if (int'(addr) < global_base(N) + M) begin
      phys  = PHYS_W'(int'(addr) - global_base(N));
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/rf_windowed.sv
// Windowed register file: M globals plus F overlapping IN/LOCAL/OUT windows,
// spilling the oldest window to memory on overflow and filling it back on underflow.
module rf_windowed
  import rf_pkg::*;
#(
  parameter int NBITS      = 64,
  parameter int NREGISTERS = 32,
  parameter int N          = 3,
  parameter int F          = 4,
  parameter int M          = 5,
  localparam int ADDR_W    = rf_log2(3 * N + M + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rf_rd1,
  input  logic              rf_rd2,
  input  logic              rf_wr,
  input  logic              rf_call,
  input  logic              rf_sigreturn,
  input  logic [ADDR_W-1:0] rf_add_wr,
  input  logic [ADDR_W-1:0] rf_add_rd1,
  input  logic [ADDR_W-1:0] rf_add_rd2,
  input  logic [NBITS-1:0]  rf_data_in,
  input  logic [NBITS-1:0]  rf_mem_busRead,
  output logic [NBITS-1:0]  rf_out1,
  output logic [NBITS-1:0]  rf_out2,
  output logic [NBITS-1:0]  rf_mem_bus,
  output logic              rf_spill,
  output logic              rf_fill
);

  localparam int PHYS_W = rf_log2(NREGISTERS);
  localparam int WIN_W  = (F > 1) ? rf_log2(F) : 1;
  localparam int RES_W  = rf_log2(F + 1);
  localparam int CNT_W  = (N > 1) ? rf_log2(2 * N) : 1;
  localparam int WORDS  = 2 * N;

  rf_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIN_W-1:0]  cwin_reg, cwin_next;
  logic [WIN_W-1:0]  swin_reg, swin_next;
  logic [RES_W-1:0]  res_reg, res_next;
  logic [15:0]       depth_reg, depth_next;
  logic [NBITS-1:0]  out1_reg, out2_reg;
  logic [NBITS-1:0]  reg_words [NREGISTERS];

  logic [ADDR_W-1:0] map_addr  [3];
  logic [PHYS_W-1:0] map_phys  [3];
  logic              map_valid [3];
  logic [NBITS-1:0]  rd_data   [1:2];

  logic              act, wr_en, call_ok, ret_ok, last_word;
  logic [WIN_W-1:0]  fill_win;
  logic [PHYS_W-1:0] spill_phys, fill_phys;

  function automatic logic [WIN_W-1:0] win_inc(input logic [WIN_W-1:0] w);
    return (int'(w) == F - 1) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [WIN_W-1:0] win_dec(input logic [WIN_W-1:0] w);
    return (w == '0) ? WIN_W'(F - 1) : w - 1'b1;
  endfunction

  assign map_addr[0] = rf_add_wr;
  assign map_addr[1] = rf_add_rd1;
  assign map_addr[2] = rf_add_rd2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_map
    rf_addr_map #(
      .N(N), .F(F), .M(M), .ADDR_W(ADDR_W), .WIN_W(WIN_W), .PHYS_W(PHYS_W)
    ) u_map (
      .addr  (map_addr[gi]),
      .cwin  (cwin_reg),
      .phys  (map_phys[gi]),
      .valid (map_valid[gi])
    );
  end

  assign act       = enable && (state_reg == IDLE);
  assign wr_en     = act && rf_wr && map_valid[0];
  assign call_ok   = act && rf_call && !rf_sigreturn;
  assign ret_ok    = act && rf_sigreturn && !rf_call;
  assign last_word = (int'(cnt_reg) == WORDS - 1);

  // Fill restores the window just below the oldest resident one, top word first.
  assign fill_win   = win_dec(swin_reg);
  assign spill_phys = PHYS_W'(win_phys(N, M, F, int'(swin_reg), int'(cnt_reg)));
  assign fill_phys  = PHYS_W'(win_phys(N, M, F, int'(fill_win), WORDS - 1 - int'(cnt_reg)));

  for (genvar gi = 0; gi < NREGISTERS; gi++) begin : g_reg
    logic [NBITS-1:0] word_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) word_reg <= '0;
      else if (wr_en && int'(map_phys[0]) == gi) word_reg <= rf_data_in;
      else if (state_reg == FILL && int'(fill_phys) == gi) word_reg <= rf_mem_busRead;
    end
    assign reg_words[gi] = word_reg;
  end

  // A read of the register being written this cycle sees the incoming data.
  for (genvar gi = 1; gi < 3; gi++) begin : g_rd
    assign rd_data[gi] = !map_valid[gi] ? '0 :
                         (wr_en && map_phys[0] == map_phys[gi]) ? rf_data_in :
                         reg_words[map_phys[gi]];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cwin_next  = cwin_reg;
    swin_next  = swin_reg;
    res_next   = res_reg;
    depth_next = depth_reg;
    unique case (state_reg)
      IDLE: begin
        if (call_ok) begin
          if (int'(res_reg) < F) begin
            cwin_next = win_inc(cwin_reg);
            res_next  = res_reg + 1'b1;
          end else begin
            state_next = SPILL;
            cnt_next   = '0;
          end
        end else if (ret_ok) begin
          if (int'(res_reg) > 1) begin
            cwin_next = win_dec(cwin_reg);
            res_next  = res_reg - 1'b1;
          end else if (depth_reg != '0) begin
            state_next = FILL;
            cnt_next   = '0;
          end
        end
      end
      SPILL: begin
        if (last_word) begin
          state_next = IDLE;
          cnt_next   = '0;
          cwin_next  = win_inc(cwin_reg);
          swin_next  = win_inc(swin_reg);
          depth_next = (&depth_reg) ? depth_reg : depth_reg + 16'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FILL: begin
        if (last_word) begin
          state_next = IDLE;
          cnt_next   = '0;
          cwin_next  = win_dec(cwin_reg);
          swin_next  = fill_win;
          depth_next = depth_reg - 16'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cwin_reg  <= '0;
      swin_reg  <= '0;
      res_reg   <= RES_W'(1);
      depth_reg <= '0;
      out1_reg  <= '0;
      out2_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cwin_reg  <= cwin_next;
      swin_reg  <= swin_next;
      res_reg   <= res_next;
      depth_reg <= depth_next;
      if (act && rf_rd1) out1_reg <= rd_data[1];
      if (act && rf_rd2) out2_reg <= rd_data[2];
    end
  end

  assign rf_out1    = out1_reg;
  assign rf_out2    = out2_reg;
  assign rf_spill   = (state_reg == SPILL);
  assign rf_fill    = (state_reg == FILL);
  assign rf_mem_bus = (state_reg == SPILL) ? reg_words[spill_phys] : '0;

endmodule

// File: tb/tb_rf_windowed.sv
// Bench for rf_windowed: directed window/spill/fill scenarios plus random traffic,
// all checked against an integer model of windows, a flat register array and a memory stack.
module tb_rf_windowed;

  localparam int NBITS    = 64;
  localparam int NREG     = 32;
  localparam int N        = 3;
  localparam int F        = 4;
  localparam int M        = 5;
  localparam int WORDS    = 2 * N;
  localparam int WIN_REGS = 2 * N * F;
  localparam int GBASE    = 3 * N;

  localparam int MODE_RUN   = 0;
  localparam int MODE_SPILL = 1;
  localparam int MODE_FILL  = 2;

  logic             clk, rst, enable, rf_rd1, rf_rd2, rf_wr, rf_call, rf_sigreturn;
  logic [3:0]       rf_add_wr, rf_add_rd1, rf_add_rd2;
  logic [NBITS-1:0] rf_data_in, rf_mem_busRead, rf_out1, rf_out2, rf_mem_bus;
  logic             rf_spill, rf_fill;

  int               n_cmp, n_bad, cyc, spill_cnt, fill_cnt;
  logic [NBITS-1:0] first_bus;

  // Reference model state
  logic [NBITS-1:0] m_regs [NREG];
  logic [NBITS-1:0] m_out1, m_out2;
  logic [NBITS-1:0] m_stack [$];
  int               m_cwin, m_swin, m_res, m_depth, m_mode, m_cnt;

  rf_windowed dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .rf_wr          (rf_wr),
    .rf_call        (rf_call),
    .rf_sigreturn   (rf_sigreturn),
    .rf_add_wr      (rf_add_wr),
    .rf_add_rd1     (rf_add_rd1),
    .rf_add_rd2     (rf_add_rd2),
    .rf_data_in     (rf_data_in),
    .rf_mem_busRead (rf_mem_busRead),
    .rf_out1        (rf_out1),
    .rf_out2        (rf_out2),
    .rf_mem_bus     (rf_mem_bus),
    .rf_spill       (rf_spill),
    .rf_fill        (rf_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lphys(input int a, input int win);
    if (a < GBASE) return M + ((2 * N * win + a) % WIN_REGS);
    if (a < GBASE + M) return a - GBASE;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_out1 = '0; m_out2 = '0;
    m_cwin = 0; m_swin = 0; m_res = 1; m_depth = 0;
    m_mode = MODE_RUN; m_cnt = 0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic en, input logic r1, input logic r2, input logic w,
                            input logic c, input logic s, input int aw, input int a1,
                            input int a2, input logic [63:0] din, input logic [63:0] fdat);
    int pw, p1, p2, tw;
    if (m_mode == MODE_RUN) begin
      if (en) begin
        pw = lphys(aw, m_cwin);
        p1 = lphys(a1, m_cwin);
        p2 = lphys(a2, m_cwin);
        if (r1) m_out1 = (p1 < 0) ? '0 : (w && pw == p1) ? din : m_regs[p1];
        if (r2) m_out2 = (p2 < 0) ? '0 : (w && pw == p2) ? din : m_regs[p2];
        if (w && pw >= 0) m_regs[pw] = din;
        if (c && !s) begin
          if (m_res < F) begin m_cwin = (m_cwin + 1) % F; m_res++; end
          else begin m_mode = MODE_SPILL; m_cnt = 0; end
        end else if (s && !c) begin
          if (m_res > 1) begin m_cwin = (m_cwin + F - 1) % F; m_res--; end
          else if (m_depth > 0) begin m_mode = MODE_FILL; m_cnt = 0; end
        end
      end
    end else if (m_mode == MODE_SPILL) begin
      m_stack.push_back(m_regs[M + ((2 * N * m_swin + m_cnt) % WIN_REGS)]);
      m_cnt++;
      if (m_cnt == WORDS) begin
        m_mode = MODE_RUN;
        m_cwin = (m_cwin + 1) % F;
        m_swin = (m_swin + 1) % F;
        if (m_depth < 65535) m_depth++;
      end
    end else begin
      tw = (m_swin + F - 1) % F;
      m_regs[M + ((2 * N * tw + WORDS - 1 - m_cnt) % WIN_REGS)] = fdat;
      if (m_stack.size() > 0) void'(m_stack.pop_back());
      m_cnt++;
      if (m_cnt == WORDS) begin
        m_mode = MODE_RUN;
        m_cwin = (m_cwin + F - 1) % F;
        m_swin = tw;
        m_depth--;
      end
    end
  endtask

  // One clock: drive inputs at posedge+1, check outputs, advance the model, return at next posedge+1.
  task automatic cycle(input logic en, input logic r1, input logic r2, input logic w,
                       input logic c, input logic s, input int aw, input int a1,
                       input int a2, input logic [63:0] din);
    logic [63:0] fdat, exp_bus;
    enable = en; rf_rd1 = r1; rf_rd2 = r2; rf_wr = w; rf_call = c; rf_sigreturn = s;
    rf_add_wr = 4'(aw); rf_add_rd1 = 4'(a1); rf_add_rd2 = 4'(a2); rf_data_in = din;
    fdat = {$urandom, $urandom};
    if (m_mode == MODE_FILL && m_stack.size() > 0) fdat = m_stack[$];
    rf_mem_busRead = fdat;
    #1;
    exp_bus = (m_mode == MODE_SPILL) ? m_regs[M + ((2 * N * m_swin + m_cnt) % WIN_REGS)] : '0;
    chk("out1", rf_out1, m_out1);
    chk("out2", rf_out2, m_out2);
    chk("spill", 64'(rf_spill), 64'(m_mode == MODE_SPILL));
    chk("fill", 64'(rf_fill), 64'(m_mode == MODE_FILL));
    chk("mem_bus", rf_mem_bus, exp_bus);
    if (rf_spill) begin
      if (spill_cnt == 0) first_bus = rf_mem_bus;
      spill_cnt++;
    end
    if (rf_fill) fill_cnt++;
    $display("cyc %0d en=%0b rd=%0b%0b wr=%0b call=%0b ret=%0b aw=%0d a1=%0d a2=%0d out1=%h out2=%h spill=%0b fill=%0b",
             cyc, en, r1, r2, w, c, s, aw, a1, a2, rf_out1, rf_out2, rf_spill, rf_fill);
    model_step(en, r1, r2, w, c, s, aw, a1, a2, din, fdat);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic op_nop();  cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, '0); endtask
  task automatic op_call(); cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, '0); endtask
  task automatic op_ret();  cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, '0); endtask
  task automatic op_wr(input int a, input logic [63:0] d);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, 0, 0, d);
  endtask
  task automatic op_rd(input int a1, input int a2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, a1, a2, '0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; spill_cnt = 0; fill_cnt = 0; first_bus = '0;
    rst = 1'b0; enable = 1'b0; rf_rd1 = 1'b0; rf_rd2 = 1'b0; rf_wr = 1'b0;
    rf_call = 1'b0; rf_sigreturn = 1'b0; rf_add_wr = '0; rf_add_rd1 = '0; rf_add_rd2 = '0;
    rf_data_in = '0; rf_mem_busRead = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Global and window read-back, out-of-range read
    op_wr(GBASE, 64'hA5);
    op_wr(0, 64'h11);
    op_rd(GBASE, 0);
    chk("t2_global0", rf_out1, 64'hA5);
    chk("t2_in0", rf_out2, 64'h11);
    op_rd(15, 14);
    chk("t2_oob15", rf_out1, 64'h0);
    chk("t2_oob14", rf_out2, 64'h0);

    // OUT of caller becomes IN of callee
    op_wr(2 * N, 64'h22);
    op_call();
    op_rd(0, GBASE);
    chk("t3_in0_after_call", rf_out1, 64'h22);
    chk("t3_global_call", rf_out2, 64'hA5);
    op_ret();
    op_rd(2 * N, GBASE);
    chk("t3_out0_after_ret", rf_out1, 64'h22);
    chk("t3_global_ret", rf_out2, 64'hA5);

    // Overflow: only the F-th call spills
    spill_cnt = 0;
    for (int w = 0; w < F; w++) begin
      op_wr(0, 64'h100 + 64'(w));
      if (w == F - 1) chk("t4_no_early_spill", 64'(spill_cnt), 64'd0);
      op_call();
    end
    repeat (8) op_nop();
    chk("t4_spill_cycles", 64'(spill_cnt), 64'(WORDS));
    chk("t4_first_word", first_bus, 64'h100);

    // Underflow: only the return with one resident window fills
    fill_cnt = 0;
    repeat (F - 1) op_ret();
    chk("t5_no_early_fill", 64'(fill_cnt), 64'd0);
    op_ret();
    repeat (8) op_nop();
    chk("t5_fill_cycles", 64'(fill_cnt), 64'(WORDS));
    op_rd(0, GBASE);
    chk("t5_in0_restored", rf_out1, 64'h100);

    // Return at base ignored, call+return ignored, bypass
    fill_cnt = 0;
    op_ret();
    repeat (3) op_nop();
    chk("t6_ret_ignored", 64'(fill_cnt), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, '0);
    op_rd(0, GBASE);
    chk("t6_call_ret_ignored", rf_out1, 64'h100);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4, 0, 64'h5555);
    chk("t6_bypass", rf_out1, 64'h5555);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            {$urandom, $urandom});
    end

    // Reset in the middle of a spill
    for (int i = 0; i < 2 * F + 2 && m_mode != MODE_SPILL; i++) op_call();
    op_nop();
    chk("t1_spill_active", 64'(rf_spill), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_out1", rf_out1, 64'h0);
    chk("t1_rst_out2", rf_out2, 64'h0);
    chk("t1_rst_bus", rf_mem_bus, 64'h0);
    chk("t1_rst_spill", 64'(rf_spill), 64'd0);
    chk("t1_rst_fill", 64'(rf_fill), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    op_ret();
    op_rd(GBASE, 0);
    chk("t1_regs_cleared_g", rf_out1, 64'h0);
    chk("t1_regs_cleared_in", rf_out2, 64'h0);
    repeat (4) op_nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_windowed.md
Name: rf_windowed

Overview:
- Windowed register file for the integer datapath.
- Holds M global registers plus F circular windows of IN/LOCAL/OUT registers, each N wide; adjacent windows share OUT/IN.
- Subroutine call/return slides the current window.
- On window overflow it spills the oldest window to an external memory stack over rf_mem_bus; on underflow it fills a window back from rf_mem_busRead.

Parameters:
- NBITS, 64, data width.
- NREGISTERS, 32, physical register capacity; must be >= M+2*N*F.
- N, 3, registers per IN/LOCAL/OUT group.
- F, 4, number of windows.
- M, 5, number of global registers.
- ADDR_W, $clog2(3*N+M+1) (=4), logical address width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- enable  in  1  global enable for read/write/call/return.
- rf_rd1  in  1  read request, port 1.
- rf_rd2  in  1  read request, port 2.
- rf_wr  in  1  write request.
- rf_call  in  1  subroutine call (one-cycle pulse).
- rf_sigreturn  in  1  subroutine return (one-cycle pulse).
- rf_add_wr  in  ADDR_W  logical write address.
- rf_add_rd1  in  ADDR_W  logical read address, port 1.
- rf_add_rd2  in  ADDR_W  logical read address, port 2.
- rf_data_in  in  NBITS  write data.
- rf_mem_busRead  in  NBITS  fill data from memory.
- rf_out1  out  NBITS  read data, port 1 (registered).
- rf_out2  out  NBITS  read data, port 2 (registered).
- rf_mem_bus  out  NBITS  spill data to memory.
- rf_spill  out  1  high while a spill word is valid on rf_mem_bus.
- rf_fill  out  1  high while a fill word is expected on rf_mem_busRead.

Behaviour:
- Reset (rst=0, async):
  - All physical registers and all outputs go to 0.
  - State reset: cwin=0, swin=0 (oldest resident window), R=1 (resident windows), depth=0 (spilled windows).
- Logical map (a = address):
  - 0..N-1 = IN, N..2N-1 = LOCAL, 2N..3N-1 = OUT → phys = M + ((2N*cwin + a) mod 2NF).
  - 3N..3N+M-1 = GLOBAL → phys = a-3N.
  - a >= 3N+M: read returns 0, write ignored.
- Normal operation (state IDLE, enable=1):
  - Write: rf_wr writes rf_data_in at the rising edge.
  - Read: rf_rdX loads rf_outX at the rising edge (1-cycle latency). Without rf_rdX, rf_outX holds.
  - Read and write to the same physical register in one cycle: read returns rf_data_in (bypass).
  - Read/write in the same cycle as call/return use the pre-call window.
- enable=0: no register, window or output change (an in-progress spill/fill still continues).
- Call:
  - R<F: cwin++, R++ (mod F).
  - R==F: enter SPILL, then cwin++, swin++, depth++.
- Return:
  - R>1: cwin--, R--.
  - R==1 and depth>0: enter FILL, then cwin--, swin--, depth--.
  - R==1 and depth==0: ignored.
- rf_call and rf_sigreturn together: both ignored.
- FSM IDLE→SPILL→IDLE:
  - 2N cycles starting the cycle after the call.
  - rf_spill=1; rf_mem_bus = window swin IN/LOCAL word k, k=0..2N-1 ascending.
- FSM IDLE→FILL→IDLE:
  - 2N cycles; rf_fill=1.
  - rf_mem_busRead is sampled each edge into new window swin, word k=2N-1..0 descending (LIFO-consistent with spill).
- While SPILL/FILL: rf_rd*, rf_wr, call, return are ignored; rf_out* hold.
- Outside SPILL: rf_mem_bus=0 and rf_spill=0. Outside FILL: rf_fill=0.
- depth is a 16-bit counter, saturating at its maximum.
- Reset mid-spill/fill aborts to IDLE with reset state.

Decomposition:
- Package rf_pkg:
  - state enum {IDLE,SPILL,FILL}.
  - LOG2 macro/function.
  - Helpers for address-class constants (IN/LOCAL/OUT/GLOBAL bases).
- One sub-module, rf_addr_map: combinational logical→physical translation, instantiated 3× (wr, rd1, rd2).

Test Plan:
1. Reset with rst=0 mid-activity → rf_out1=rf_out2=rf_mem_bus=0, rf_spill=rf_fill=0.
2. Global/window read-back:
   - Write 0xA5 to logical 3N (global 0) and 0x11 to logical 0 (IN0).
   - Read both on rd1/rd2 → rf_out1=0xA5, rf_out2=0x11 one cycle later.
   - Read address 15 → 0.
3. Overlap:
   - Write 0x22 to OUT0 (logical 2N), call, read IN0 → 0x22.
   - Return, read OUT0 → 0x22.
   - Global 0 unchanged across the call.
4. Overflow:
   - Write IN0=0x100+w in each window, then perform F calls.
   - On the F-th call, rf_spill is high exactly 2N=6 cycles; first rf_mem_bus word = 0x100.
   - No spill on calls 1..F-1.
5. Underflow:
   - After test 4, return F times.
   - On the return with R==1, rf_fill is high 6 cycles; drive the spilled words back in reverse order.
   - Afterwards IN0 reads 0x100.
6. Return at reset state → ignored. Simultaneous call+return → ignored. Read+write to the same address → bypass value returned.
